// File: rtl/tick_timer_pkg.sv
// rtl/tick_timer_pkg.sv - shared timer state encoding and project-wide tick defaults
package tick_timer_pkg;

    // Project-wide default clk cycles per enable tick, shared with the light controller
    localparam int DEFAULT_PRESCALE = 10;

    // Timer FSM states; the light controller decodes the same encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running clock divider producing a one-cycle enable tick
module tick_prescaler
    import tick_timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PS_WIDTH = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic enable
);

    localparam logic [PS_WIDTH-1:0] LAST = PS_WIDTH'(PRESCALE - 1);
    localparam logic [PS_WIDTH-1:0] ONE  = PS_WIDTH'(1);

    logic [PS_WIDTH-1:0] count;

    // Count 0..PRESCALE-1 and register the tick; the clearing cycle itself is count 0,
    // so the count leaving it is 1 and the first tick lands PRESCALE cycles after it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            enable <= 1'b0;
        end else if (clear) begin
            count  <= ONE;
            enable <= 1'b0;
        end else begin
            enable <= (count == LAST);
            count  <= (count == LAST) ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick-based one-shot / auto-reload countdown timer
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int PRESCALE  = DEFAULT_PRESCALE,
    parameter int PS_WIDTH  = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startTimer,
    input  logic [CNT_WIDTH-1:0] duration,
    input  logic                 periodic,
    input  logic                 stopTimer,
    output logic                 enable,
    output logic                 busy,
    output logic                 expired,
    output logic [CNT_WIDTH-1:0] remaining
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    timer_state_e         state_q;
    timer_state_e         state_d;
    logic [CNT_WIDTH-1:0] rem_d;
    logic [CNT_WIDTH-1:0] dur_q;
    logic [CNT_WIDTH-1:0] dur_d;
    logic                 per_q;
    logic                 per_d;
    logic                 exp_d;
    logic                 start_ok;

    // A stop in the same cycle wins, so only an unopposed start realigns the tick phase
    assign start_ok = startTimer && !stopTimer;

    tick_prescaler #(
        .PRESCALE(PRESCALE),
        .PS_WIDTH(PS_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .enable(enable)
    );

    // Next-state: stop beats start, start beats a coincident terminal tick
    always_comb begin
        state_d = state_q;
        rem_d   = remaining;
        dur_d   = dur_q;
        per_d   = per_q;
        exp_d   = 1'b0;
        if (stopTimer) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (startTimer) begin
            if (duration == '0) begin
                state_d = ST_IDLE;
                rem_d   = '0;
                exp_d   = 1'b1;
            end else begin
                state_d = ST_RUN;
                rem_d   = duration;
                dur_d   = duration;
                per_d   = periodic;
            end
        end else if (state_q == ST_RUN && enable && remaining != '0) begin
            if (remaining == CNT_ONE) begin
                exp_d = 1'b1;
                if (per_q) begin
                    rem_d = dur_q;
                end else begin
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end
            end else begin
                rem_d = remaining - CNT_ONE;
            end
        end
    end

    // State and output registers; busy is a registered decode of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            busy      <= 1'b0;
            expired   <= 1'b0;
            remaining <= '0;
            dur_q     <= '0;
            per_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d == ST_RUN);
            expired   <= exp_d;
            remaining <= rem_d;
            dur_q     <= dur_d;
            per_q     <= per_d;
        end
    end

endmodule
